// File: rtl/rot16_pkg.sv
// Shared constants, state encoding, operation payload and helpers for the rot16 rotate sequencer.
package rot16_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SHW   = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PASS_L = 2'd1;
  localparam logic [1:0] PASS_R = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic             id;
  } rot_op_t;

  function automatic logic [WIDTH-1:0] bitrev16(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      r[i] = v[int'(WIDTH) - 1 - i];
    end
    return r;
  endfunction

  // Right rotate by n is the left rotate by (WIDTH - n) mod WIDTH.
  function automatic logic [SHW-1:0] eff_amt(input logic [SHW-1:0] n, input logic dir);
    return dir ? SHW'(WIDTH - 32'(n)) : n;
  endfunction

endpackage

// File: rtl/lshift16_core.sv
// Combinational 16-bit logarithmic left barrel shifter (zero fill).
module lshift16_core
  import rot16_pkg::*;
(
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] s0_c;
  logic [WIDTH-1:0] s1_c;
  logic [WIDTH-1:0] s2_c;

  always_comb begin
    s0_c = amt[0] ? {in[WIDTH-2:0], 1'b0}   : in;
    s1_c = amt[1] ? {s0_c[WIDTH-3:0], 2'b0} : s0_c;
    s2_c = amt[2] ? {s1_c[WIDTH-5:0], 4'b0} : s1_c;
    out  = amt[3] ? {s2_c[WIDTH-9:0], 8'b0} : s2_c;
  end

endmodule

// File: rtl/rot16_sched.sv
// Two-port arbiter and sequencer building 16-bit rotate-left from two passes of one shared left shifter.
// Optional LROT_DIR_EN adds per-requester direction inputs (0 = left, 1 = right).
module rot16_sched
  import rot16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [SHW-1:0]   req0_amt,
`ifdef LROT_DIR_EN
  input  logic             req0_dir,
`endif
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [SHW-1:0]   req1_amt,
`ifdef LROT_DIR_EN
  input  logic             req1_dir,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  rot_op_t          op_q, op_d;
  rot_op_t          req0_op_c, req1_op_c, sel_op_c;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             last_grant_q, last_grant_d;
  logic             grant0_c, grant1_c;
  logic [WIDTH-1:0] sh_in_c, sh_out_c;
  logic [SHW-1:0]   sh_amt_c;

  // Request payloads; a right rotate is folded into its equivalent left amount.
  always_comb begin
    req0_op_c = '{data: req0_data, amt: req0_amt, id: 1'b0};
    req1_op_c = '{data: req1_data, amt: req1_amt, id: 1'b1};
`ifdef LROT_DIR_EN
    req0_op_c.amt = eff_amt(req0_amt, req0_dir);
    req1_op_c.amt = eff_amt(req1_amt, req1_dir);
`endif
  end

  // Round-robin grant, only offered while idle and out of reset.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state_q == IDLE && !rst) begin
      grant0_c = req0_valid && (!req1_valid || last_grant_q);
      grant1_c = req1_valid && (!req0_valid || !last_grant_q);
    end
    sel_op_c = grant1_c ? req1_op_c : req0_op_c;
  end

  // Second pass shifts the reversed operand by WIDTH-n to produce the wrapped bits.
  always_comb begin
    sh_in_c  = op_q.data;
    sh_amt_c = op_q.amt;
    if (state_q == PASS_R) begin
      sh_in_c  = bitrev16(op_q.data);
      sh_amt_c = SHW'(WIDTH - 32'(op_q.amt));
    end
  end

  lshift16_core u_shift (
    .in  (sh_in_c),
    .amt (sh_amt_c),
    .out (sh_out_c)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    lo_d         = lo_q;
    res_d        = res_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant0_c || grant1_c) begin
          op_d         = sel_op_c;
          last_grant_d = grant1_c;
          if (sel_op_c.amt == '0) begin
            res_d   = sel_op_c.data;
            state_d = DONE;
          end else begin
            state_d = PASS_L;
          end
        end
      end
      PASS_L: begin
        lo_d    = sh_out_c;
        state_d = PASS_R;
      end
      PASS_R: begin
        res_d   = lo_q | bitrev16(sh_out_c);
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      lo_q         <= '0;
      res_q        <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      lo_q         <= lo_d;
      res_q        <= res_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req0_ready = grant0_c;
  assign req1_ready = grant1_c;
  assign out_valid  = out_valid_q;
  assign out_data   = res_q;
  assign out_id     = op_q.id;
  assign busy       = busy_q;

endmodule
